dependancy_scoreboard: RTL and testbench

//  Issue scoreboard fed by dependancy_generation. Holds the read/write/special dependency vectors
//  of every in-flight instruction, decides each cycle whether the decoded instruction may issue
//  (RAW/WAR/WAW/memory/jump hazards), allocates it a slot on issue and frees slots on retire.

---
 rtl/dependancy_scoreboard.sv | 121 ++++++++++++
 tb/tb_dependancy_scoreboard.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dependancy_scoreboard.sv
// Issue scoreboard: tracks in-flight dependency vectors and gates issue.
// Allocates the lowest free slot on issue, frees slots on retire or flush.
module dependancy_scoreboard #(
   parameter int SLOTS     = 8,
   parameter int SLOT_BITS = 3
) (
   input  logic                 main_clk,
   input  logic                 main_reset,
   input  logic                 new_valid,
   input  logic [16:0]          new_depend_read,
   input  logic [16:0]          new_depend_write,
   input  logic [2:0]           new_depend_special,
   output logic                 new_ready,
   output logic [SLOT_BITS-1:0] issue_slot,
   input  logic                 retire_valid,
   input  logic [SLOT_BITS-1:0] retire_slot,
   input  logic                 flush,
   output logic [16:0]          pending_write,
   output logic [SLOT_BITS:0]   occupancy,
   output logic                 full,
   output logic                 empty,
   output logic [15:0]          stall_cycles
);

   logic [SLOTS-1:0] slotValid;
   logic [16:0]      slotRead    [SLOTS];
   logic [16:0]      slotWrite   [SLOTS];
   logic [2:0]       slotSpecial [SLOTS];
   logic [SLOT_BITS:0] occCount;
   logic [15:0]      stallCount;
   logic             hazard;
   logic             freeFound;
   logic             doIssue;
   logic             doRetire;

   assign occupancy    = occCount;
   assign stall_cycles = stallCount;
   assign full         = (occCount == (SLOT_BITS+1)'(SLOTS));
   assign empty        = (occCount == '0);
   assign new_ready    = ~main_reset & ~flush & ~full & ~hazard;
   assign doIssue      = new_valid & new_ready;
   assign doRetire     = retire_valid & slotValid[retire_slot];

   // Hazard check of the incoming instruction against every live slot.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (slotValid[i]) begin
            if (|(new_depend_read & slotWrite[i]))
               hazard = 1'b1;
            if (|(new_depend_write & slotRead[i]))
               hazard = 1'b1;
            if (|(new_depend_write & slotWrite[i]))
               hazard = 1'b1;
            if (slotSpecial[i][0] | new_depend_special[0])
               hazard = 1'b1;
            if (new_depend_special[1] & slotSpecial[i][2])
               hazard = 1'b1;
            if (new_depend_special[2] &
                (slotSpecial[i][1] | slotSpecial[i][2]))
               hazard = 1'b1;
         end
      end
   end

   // Union of register writes still outstanding.
   always_comb begin
      pending_write = '0;
      for (int i = 0; i < SLOTS; i++)
         if (slotValid[i])
            pending_write = pending_write | slotWrite[i];
   end

   // Lowest-index free slot; zero when none is free.
   always_comb begin
      issue_slot = '0;
      freeFound  = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (!slotValid[i] && !freeFound) begin
            issue_slot = SLOT_BITS'(i);
            freeFound  = 1'b1;
         end
      end
   end

   // Slot allocation, retirement, flush and occupancy tracking.
   always_ff @(posedge main_clk) begin
      if (main_reset) begin
         slotValid <= '0;
         occCount  <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            slotRead[i]    <= '0;
            slotWrite[i]   <= '0;
            slotSpecial[i] <= '0;
         end
      end else if (flush) begin
         slotValid <= '0;
         occCount  <= '0;
      end else begin
         if (doRetire)
            slotValid[retire_slot] <= 1'b0;
         if (doIssue) begin
            slotValid[issue_slot]   <= 1'b1;
            slotRead[issue_slot]    <= new_depend_read;
            slotWrite[issue_slot]   <= new_depend_write;
            slotSpecial[issue_slot] <= new_depend_special;
         end
         occCount <= occCount + (SLOT_BITS+1)'(doIssue)
                              - (SLOT_BITS+1)'(doRetire);
      end
   end

   // Saturating count of cycles an instruction waited on a hazard.
   always_ff @(posedge main_clk) begin
      if (main_reset)
         stallCount <= '0;
      else if (new_valid && !new_ready && stallCount != 16'hFFFF)
         stallCount <= stallCount + 16'd1;
   end

endmodule

// File: tb/tb_dependancy_scoreboard.sv
// Randomized and directed check of dependancy_scoreboard
// against a slot-table reference model.
module tb_dependancy_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        nv;
   logic [16:0] nr;
   logic [16:0] nw;
   logic [2:0]  ns;
   logic        ready;
   logic [2:0]  islot;
   logic        rv;
   logic [2:0]  rs;
   logic        fl;
   logic [16:0] pw;
   logic [3:0]  occ;
   logic        full;
   logic        empty;
   logic [15:0] stall;

   int total = 0;
   int bad   = 0;
   bit chk   = 0;

   bit          mValid [8];
   logic [16:0] mRead  [8];
   logic [16:0] mWrite [8];
   logic [2:0]  mSpec  [8];
   int          mStall = 0;

   dependancy_scoreboard #(.SLOTS(8), .SLOT_BITS(3)) dut (
      .main_clk(clk), .main_reset(rst), .new_valid(nv),
      .new_depend_read(nr), .new_depend_write(nw),
      .new_depend_special(ns), .new_ready(ready),
      .issue_slot(islot), .retire_valid(rv), .retire_slot(rs),
      .flush(fl), .pending_write(pw), .occupancy(occ),
      .full(full), .empty(empty), .stall_cycles(stall)
   );

   always #5 clk = ~clk;

   function automatic int mOcc();
      int n = 0;
      for (int i = 0; i < 8; i++) n += mValid[i] ? 1 : 0;
      return n;
   endfunction

   function automatic bit conflicts(int i);
      if ((nr & mWrite[i]) != 0) return 1;
      if ((nw & mRead[i]) != 0) return 1;
      if ((nw & mWrite[i]) != 0) return 1;
      if (mSpec[i][0]) return 1;
      if (ns[1] && mSpec[i][2]) return 1;
      if (ns[2] && (mSpec[i][1] || mSpec[i][2])) return 1;
      return 0;
   endfunction

   function automatic bit mReady();
      if (rst || fl || mOcc() == 8) return 0;
      if (ns[0] && mOcc() != 0) return 0;
      for (int i = 0; i < 8; i++)
         if (mValid[i] && conflicts(i)) return 0;
      return 1;
   endfunction

   function automatic int mSlot();
      for (int i = 0; i < 8; i++)
         if (!mValid[i]) return i;
      return 0;
   endfunction

   function automatic int mPend();
      int p = 0;
      for (int i = 0; i < 8; i++)
         if (mValid[i]) p |= int'(mWrite[i]);
      return p;
   endfunction

   task automatic cmp(string n, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", n, act, exp, $time);
      end
   endtask

   task automatic checkAll();
      cmp("new_ready", int'(ready), int'(mReady()));
      cmp("issue_slot", int'(islot), mSlot());
      cmp("pending_write", int'(pw), mPend());
      cmp("occupancy", int'(occ), mOcc());
      cmp("full", int'(full), (mOcc() == 8) ? 1 : 0);
      cmp("empty", int'(empty), (mOcc() == 0) ? 1 : 0);
      cmp("stall_cycles", int'(stall), mStall);
   endtask

   task automatic modelAdvance();
      bit r;
      int s;
      r = mReady();
      s = mSlot();
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            mValid[i] = 0;
            mRead[i]  = '0;
            mWrite[i] = '0;
            mSpec[i]  = '0;
         end
         mStall = 0;
      end else begin
         if (nv && !r && mStall < 65535) mStall++;
         if (fl) begin
            for (int i = 0; i < 8; i++) mValid[i] = 0;
         end else begin
            if (rv) mValid[rs] = 0;
            if (nv && r) begin
               mValid[s] = 1;
               mRead[s]  = nr;
               mWrite[s] = nw;
               mSpec[s]  = ns;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk) checkAll();
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic doFlush();
      fl = 1; nv = 0; rv = 0;
      tick();
      fl = 0;
   endtask

   task automatic issueW(logic [16:0] w, logic [2:0] s);
      nv = 1; nr = '0; nw = w; ns = s;
      tick();
      nv = 0;
   endtask

   function automatic logic [16:0] sparse();
      logic [31:0] v;
      v = $urandom & $urandom & $urandom;
      return v[16:0];
   endfunction

   initial begin
      rst = 1; nv = 0; nr = '0; nw = '0; ns = '0;
      rv = 0; rs = '0; fl = 0;
      tick();
      chk = 1;
      tick();
      rst = 0;

      nv = 1; nr = '0; nw = 17'h00008; ns = '0;
      #1;
      cmp("lit_ready_first", int'(ready), 1);
      cmp("lit_slot_first", int'(islot), 0);
      tick();
      nv = 0;
      #1;
      cmp("lit_occ_one", int'(occ), 1);
      cmp("lit_pend_r3", int'(pw), 32'h8);

      nv = 1; nr = 17'h00008; nw = '0;
      #1;
      cmp("lit_raw_block", int'(ready), 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         cmp("lit_stall_count", int'(stall), k);
      end
      rv = 1; rs = 3'd0;
      tick();
      rv = 0;
      #1;
      cmp("lit_ready_after_retire", int'(ready), 1);
      cmp("lit_slot_after_retire", int'(islot), 0);
      tick();
      nv = 0;

      doFlush();
      for (int i = 0; i < 8; i++) issueW(17'(1 << i), 3'b000);
      #1;
      cmp("lit_full", int'(full), 1);
      cmp("lit_occ8", int'(occ), 8);
      cmp("lit_full_block", int'(ready), 0);
      rv = 1; rs = 3'd5; nv = 1; nr = '0; nw = 17'h10000; ns = '0;
      #1;
      cmp("lit_retire_no_free", int'(ready), 0);
      tick();
      rv = 0;
      #1;
      cmp("lit_slot5", int'(islot), 5);
      cmp("lit_ready_slot5", int'(ready), 1);
      tick();
      nv = 0;
      #1;
      cmp("lit_full_again", int'(full), 1);

      doFlush();
      issueW(17'h00002, 3'b100);
      nv = 1; nr = '0; nw = '0; ns = 3'b010;
      #1;
      cmp("lit_memrd_block", int'(ready), 0);
      ns = 3'b000; nw = 17'h00004;
      #1;
      cmp("lit_disjoint_ok", int'(ready), 1);
      tick();
      nv = 0;
      doFlush();
      issueW(17'h0, 3'b001);
      nv = 1; nr = '0; nw = 17'h00200; ns = '0;
      #1;
      cmp("lit_jump_block", int'(ready), 0);
      tick();
      rv = 1; rs = 3'd0;
      tick();
      rv = 0;
      #1;
      cmp("lit_jump_retired", int'(ready), 1);
      nv = 0;

      doFlush();
      for (int i = 0; i < 4; i++) issueW(17'(1 << i), 3'b000);
      fl = 1; rv = 1; rs = 3'd1; nv = 1; nw = 17'h01000;
      #1;
      cmp("lit_flush_block", int'(ready), 0);
      tick();
      fl = 0; rv = 0; nv = 0;
      #1;
      cmp("lit_flush_occ", int'(occ), 0);
      cmp("lit_flush_empty", int'(empty), 1);
      cmp("lit_flush_pend", int'(pw), 0);
      rv = 1; rs = 3'd3;
      tick();
      rv = 0;
      #1;
      cmp("lit_free_retire0", int'(occ), 0);
      issueW(17'h00001, 3'b000);
      rv = 1; rs = 3'd5;
      tick();
      rv = 0;
      #1;
      cmp("lit_free_retire1", int'(occ), 1);

      for (int c = 0; c < 3000; c++) begin
         nv = ($urandom_range(0, 3) != 0);
         nr = sparse();
         nw = sparse();
         ns = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         rv = ($urandom_range(0, 1) == 1);
         rs = 3'($urandom_range(0, 7));
         fl = ($urandom_range(0, 49) == 0);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 0; fl = 0; rv = 0;

      doFlush();
      issueW(17'h0, 3'b001);
      nv = 1; nr = '0; nw = 17'h00010; ns = '0;
      for (int c = 0; c < 70000; c++) tick();
      cmp("lit_stall_sat", int'(stall), 32'hFFFF);
      rst = 1;
      tick();
      rst = 0; nv = 0;
      #1;
      cmp("lit_stall_reset", int'(stall), 0);
      cmp("lit_occ_reset", int'(occ), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
